// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants, command words and parser states
package midi_pkg;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON = 4'h9;
  localparam logic [3:0] CC = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [15:0] CMD_STOP_ALL = 16'h7F00;
  localparam logic [15:0] CMD_IDLE = 16'h0000;
  typedef enum logic [2:0] {IDLE, NOTE_NUM, NOTE_VEL, CC_NUM, CC_VAL, SKIP} state_t;
endpackage

// File: rtl/midi_cmd_encoder.sv
// midi_cmd_encoder: parses a MIDI byte stream into single-cycle voice command words
module midi_cmd_encoder
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_drop
);
  state_t state, status_state;
  logic [3:0] chan;
  logic on;
  logic [6:0] d1;
  logic is_status, is_rt, ch_ok, note_bad;
  always_comb begin
    is_status = i_byte[7];
    is_rt = i_byte >= 8'hF8;
    status_state = (i_byte[7:4] == NOTE_ON || i_byte[7:4] == NOTE_OFF) ? NOTE_NUM :
                   (i_byte[7:4] == CC) ? CC_NUM : SKIP;
    ch_ok = OMNI || chan == CHANNEL[3:0];
    note_bad = d1 == 7'h00 || d1 == 7'h7F;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      chan <= 4'h0;
      on <= 1'b0;
      d1 <= 7'h00;
      o_data <= CMD_IDLE;
      o_valid <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      o_data <= CMD_IDLE;
      o_valid <= 1'b0;
      o_drop <= 1'b0;
      // real-time bytes are invisible to the parser, even mid-message
      if (i_byte_valid && !is_rt) begin
        if (is_status) begin
          state <= status_state;
          chan <= i_byte[3:0];
          on <= i_byte[7:4] == NOTE_ON;
          d1 <= 7'h00;
        end else begin
          case (state)
            NOTE_NUM: begin
              d1 <= i_byte[6:0];
              state <= NOTE_VEL;
            end
            NOTE_VEL: begin
              state <= NOTE_NUM;
              if (!ch_ok || note_bad) o_drop <= 1'b1;
              else begin
                o_valid <= 1'b1;
                o_data <= (on && i_byte[6:0] != 7'h00) ? {1'b1, d1, 1'b0, i_byte[6:0]} : {1'b0, d1, 8'h00};
              end
            end
            CC_NUM: begin
              d1 <= i_byte[6:0];
              state <= CC_VAL;
            end
            CC_VAL: begin
              state <= CC_NUM;
              if (d1 == CC_ALL_NOTES_OFF) begin
                if (ch_ok) begin
                  o_valid <= 1'b1;
                  o_data <= CMD_STOP_ALL;
                end else o_drop <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_midi_cmd_encoder.sv
// tb_midi_cmd_encoder: table-driven byte stream with a per-cycle expected-output scoreboard
module tb_midi_cmd_encoder;
  typedef struct {
    logic v;
    logic [7:0] b;
    logic ev;
    logic edrop;
    logic [15:0] ed;
  } vec_t;
  typedef struct {
    logic ev;
    logic edrop;
    logic [15:0] ed;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, i_byte_valid = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic [15:0] o_data;
  logic o_valid, o_drop;
  int checks = 0, passed = 0;
  exp_t q[$];
  vec_t vecs[$];
  midi_cmd_encoder #(.CHANNEL(0), .OMNI(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_data(o_data), .o_valid(o_valid), .o_drop(o_drop)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (o_valid === e.ev && o_drop === e.edrop && o_data === e.ed) passed++;
      else $display("FAIL out[%0d]: got valid=%b drop=%b data=%h, want valid=%b drop=%b data=%h",
                    checks, o_valid, o_drop, o_data, e.ev, e.edrop, e.ed);
    end
  end
  task automatic cyc(input logic v, input logic [7:0] b, input logic ev, input logic edrop, input logic [15:0] ed);
    @(negedge clk);
    i_byte_valid = v;
    i_byte = b;
    q.push_back('{ev, edrop, ed});
  endtask
  task automatic add(input logic v, input logic [7:0] b, input logic ev, input logic edrop, input logic [15:0] ed);
    vecs.push_back('{v, b, ev, edrop, ed});
  endtask
  initial begin
    add(1, 8'h90, 0, 0, 16'h0000); add(1, 8'h3C, 0, 0, 16'h0000); add(1, 8'h64, 1, 0, 16'hBC64);
    add(0, 8'h00, 0, 0, 16'h0000);
    add(1, 8'h40, 0, 0, 16'h0000); add(1, 8'h00, 1, 0, 16'h4000);
    add(1, 8'h80, 0, 0, 16'h0000); add(1, 8'h3C, 0, 0, 16'h0000); add(1, 8'h7F, 1, 0, 16'h3C00);
    add(1, 8'h90, 0, 0, 16'h0000); add(1, 8'h3C, 0, 0, 16'h0000); add(1, 8'hF8, 0, 0, 16'h0000);
    add(1, 8'h64, 1, 0, 16'hBC64); add(0, 8'h64, 0, 0, 16'h0000);
    add(1, 8'h3E, 0, 0, 16'h0000); add(1, 8'h64, 1, 0, 16'hBE64);
    add(1, 8'hB0, 0, 0, 16'h0000); add(1, 8'h7B, 0, 0, 16'h0000); add(1, 8'h00, 1, 0, 16'h7F00);
    add(1, 8'h07, 0, 0, 16'h0000); add(1, 8'h64, 0, 0, 16'h0000);
    add(1, 8'h91, 0, 0, 16'h0000); add(1, 8'h3C, 0, 0, 16'h0000); add(1, 8'h64, 0, 1, 16'h0000);
    add(1, 8'h90, 0, 0, 16'h0000); add(1, 8'h00, 0, 0, 16'h0000); add(1, 8'h40, 0, 1, 16'h0000);
    add(1, 8'h7F, 0, 0, 16'h0000); add(1, 8'h40, 0, 1, 16'h0000);
    add(1, 8'h90, 0, 0, 16'h0000); add(1, 8'h3C, 0, 0, 16'h0000); add(1, 8'h90, 0, 0, 16'h0000);
    add(1, 8'h3D, 0, 0, 16'h0000); add(1, 8'h64, 1, 0, 16'hBD64);
    add(1, 8'hA0, 0, 0, 16'h0000); add(1, 8'h3C, 0, 0, 16'h0000); add(1, 8'h64, 0, 0, 16'h0000);
    add(1, 8'hF0, 0, 0, 16'h0000); add(1, 8'h3C, 0, 0, 16'h0000); add(1, 8'h64, 0, 0, 16'h0000);
    add(1, 8'hB1, 0, 0, 16'h0000); add(1, 8'h7B, 0, 0, 16'h0000); add(1, 8'h00, 0, 1, 16'h0000);
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid === 1'b0 && o_drop === 1'b0 && o_data === 16'h0000) passed++;
    else $display("FAIL reset: got valid=%b drop=%b data=%h, want 0 0 0000", o_valid, o_drop, o_data);
    reset_n = 1'b1;
    foreach (vecs[i]) cyc(vecs[i].v, vecs[i].b, vecs[i].ev, vecs[i].edrop, vecs[i].ed);
    cyc(1, 8'h90, 0, 0, 16'h0000);
    cyc(1, 8'h3C, 0, 0, 16'h0000);
    @(negedge clk);
    reset_n = 1'b0;
    i_byte_valid = 1'b0;
    q.push_back('{1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    reset_n = 1'b1;
    q.push_back('{1'b0, 1'b0, 16'h0000});
    cyc(1, 8'h64, 0, 0, 16'h0000);
    cyc(1, 8'h3C, 0, 0, 16'h0000);
    cyc(1, 8'h64, 0, 0, 16'h0000);
    cyc(0, 8'h00, 0, 0, 16'h0000);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending, want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
